// File: rtl/ni_inject_arbiter.sv
// Round-robin injection arbiter: NUM_REQ NIs share one router port with bursts of up to BURST_LEN flits.
// Define NI_ARB_STATS_EN to build the saturating per-requester accepted-flit counters on grant_count.
module ni_inject_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         router_data_out,
  output logic                      router_valid_out,
  input  logic                      router_ready_in,
  output logic [2:0]                grant_id,
  output logic [NUM_REQ*16-1:0]     grant_count
);

  typedef enum logic {IDLE, LOCKED} state_e;
  localparam logic [4:0] BURST_LIM = 5'(BURST_LEN);

  state_e            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        grant_q, grant_d;
  logic [3:0]        burst_q, burst_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              load_en;
  logic              sel_found;
  logic              xfer;
  logic [2:0]        sel_idx;
  logic [3:0]        cand;
  logic [DATA_W-1:0] sel_data;

  function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
    return (32'(idx) == NUM_REQ - 1) ? 3'd0 : idx + 3'd1;
  endfunction

  // Selection and handshake: the output register frees up when empty or being drained this cycle.
  always_comb begin
    load_en   = !vld_q || router_ready_in;
    sel_found = 1'b0;
    sel_idx   = grant_q;
    cand      = '0;
    if (state_q == LOCKED) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (grant_q == 3'(i) && req_valid[i]) sel_found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, ptr_q} + 4'(k);
        if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!sel_found && cand == 4'(i) && req_valid[i]) begin
            sel_found = 1'b1;
            sel_idx   = 3'(i);
          end
        end
      end
    end
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == 3'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
      if (load_en && sel_found && sel_idx == 3'(i)) req_ready[i] = 1'b1;
    end
    xfer = load_en && sel_found;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    burst_d = burst_q;
    vld_d   = vld_q;
    data_d  = data_q;
    if (load_en) begin
      vld_d = xfer;
      if (xfer) data_d = sel_data;
    end
    case (state_q)
      IDLE: begin
        if (xfer) begin
          grant_d = sel_idx;
          burst_d = 4'd1;
          if (BURST_LEN > 1) state_d = LOCKED;
          else               ptr_d   = wrap_inc(sel_idx);
        end
      end
      LOCKED: begin
        // A stalled router keeps the burst alive; only a free slot can end it.
        if (load_en) begin
          if (xfer && ({1'b0, burst_q} + 5'd1 < BURST_LIM)) begin
            burst_d = burst_q + 4'd1;
          end else begin
            if (xfer) burst_d = burst_q + 4'd1;
            ptr_d   = wrap_inc(grant_q);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      burst_q <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      burst_q <= burst_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
    end
  end

  assign router_data_out  = data_q;
  assign router_valid_out = vld_q;
  assign grant_id         = grant_q;

`ifdef NI_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (xfer && sel_idx == 3'(i) && cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
      grant_count[i*16 +: 16] = cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  assign grant_count = '0;
`endif

endmodule
